// File: rtl/fifo_pkg.sv
// Shared async-FIFO helpers: depth derivation and Gray/binary conversion.
// Used by both the write-side and read-side pointer controllers.
package fifo_pkg;

  // Conversion functions work on a fixed wide vector. A narrower pointer
  // converts correctly when zero-extended in and size-cast back out,
  // because leading zeros do not change either transform.
  localparam int GW = 32;

  function automatic int depth_of(input int addrsize);
    return 1 << addrsize;
  endfunction

  function automatic logic [GW-1:0] bin2gray(input logic [GW-1:0] b);
    return b ^ (b >> 1);
  endfunction

  // Each binary bit is the XOR of all Gray bits at or above it.
  function automatic logic [GW-1:0] gray2bin(input logic [GW-1:0] g);
    logic [GW-1:0] b;
    b[GW-1] = g[GW-1];
    for (int i = GW-2; i >= 0; i--) b[i] = b[i+1] ^ g[i];
    return b;
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for a Gray-coded bus crossing into clk.
// Nothing may sit between the two stages.
module sync_2ff #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] meta;

  // Back-to-back capture; first stage may go metastable, second resolves it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta <= '0;
      q    <= '0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/wptr_full_ctrl.sv
// Write-domain pointer, full/almost-full, fill-count and overflow control
// for the async FIFO. Drives the RAM write port and exports the Gray
// write pointer to the read domain.
module wptr_full_ctrl
  import fifo_pkg::*;
#(
  parameter int ADDRSIZE     = 4,
  parameter int AFULL_THRESH = 12
) (
  input  logic                wclk,
  input  logic                wrst,
  input  logic                winc,
  input  logic [ADDRSIZE:0]   rptr_gray,
  output logic                wen,
  output logic [ADDRSIZE-1:0] waddr,
  output logic [ADDRSIZE:0]   wptr_gray,
  output logic                wfull,
  output logic                walmost_full,
  output logic [ADDRSIZE:0]   wcount,
  output logic                woverflow
);

  localparam int              PW       = ADDRSIZE + 1;
  localparam int              DEPTH    = depth_of(ADDRSIZE);
  // Threshold is clamped to DEPTH so an out-of-range setting still means
  // "almost full only when full" instead of silently wrapping.
  localparam logic [ADDRSIZE:0] AF_LVL =
    PW'((AFULL_THRESH > DEPTH) ? DEPTH : AFULL_THRESH);

  logic [ADDRSIZE:0] wbin;
  logic [ADDRSIZE:0] wbin_next;
  logic [ADDRSIZE:0] wgray_next;
  logic [ADDRSIZE:0] rq2_rptr;
  logic [ADDRSIZE:0] rbin_sync;
  logic [ADDRSIZE:0] cnt_next;
  logic              full_next;
  logic              afull_next;

  sync_2ff #(.WIDTH(PW)) u_sync_r2w (
    .clk (wclk),
    .rst (wrst),
    .d   (rptr_gray),
    .q   (rq2_rptr)
  );

  // Gating with wrst keeps the RAM quiet during the async reset window.
  assign wen   = winc & ~wfull & ~wrst;
  assign waddr = wbin[ADDRSIZE-1:0];

  // Next-pointer and status terms; all compare against the synced read
  // pointer, which only lags, so full/count err on the safe side.
  always_comb begin
    wbin_next  = wbin + {{ADDRSIZE{1'b0}}, wen};
    wgray_next = PW'(bin2gray(GW'(wbin_next)));
    rbin_sync  = PW'(gray2bin(GW'(rq2_rptr)));
    cnt_next   = wbin_next - rbin_sync;
    // Full when the write pointer is one lap ahead: top two Gray bits
    // inverted, the rest equal.
    full_next  = (wgray_next ==
                  {~rq2_rptr[ADDRSIZE:ADDRSIZE-1], rq2_rptr[ADDRSIZE-2:0]});
    afull_next = (cnt_next >= AF_LVL);
  end

  // Pointer and status registers, all updated from the next-state terms.
  always_ff @(posedge wclk or posedge wrst) begin
    if (wrst) begin
      wbin         <= '0;
      wptr_gray    <= '0;
      wfull        <= 1'b0;
      walmost_full <= 1'b0;
      wcount       <= '0;
    end else begin
      wbin         <= wbin_next;
      wptr_gray    <= wgray_next;
      wfull        <= full_next;
      walmost_full <= afull_next;
      wcount       <= cnt_next;
    end
  end

  // Sticky overflow: any request seen while full; cleared only by reset.
  always_ff @(posedge wclk or posedge wrst) begin
    if (wrst)               woverflow <= 1'b0;
    else if (winc && wfull) woverflow <= 1'b1;
  end

endmodule
